// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   MDTYPE_*    : operation codes presented on MDtype
//   md_state_e  : FSM state encoding (IDLE / ITER / FIX)
//   md_clog2    : ceiling log2, used to size the iteration counter
package md_pkg;

   localparam logic [2:0] MDTYPE_NONE  = 3'b000;
   localparam logic [2:0] MDTYPE_MULT  = 3'b100;
   localparam logic [2:0] MDTYPE_MULTU = 3'b101;
   localparam logic [2:0] MDTYPE_DIV   = 3'b110;
   localparam logic [2:0] MDTYPE_DIVU  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_FIX  = 2'd2
   } md_state_e;

   function automatic int md_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/md_divstep.sv
// One restoring-division step (combinational).
//   rem_in  : current partial remainder (always < divisor)
//   divisor : divisor magnitude
//   bit_in  : next dividend bit shifted into the remainder
//   rem_out : new partial remainder
//   q_bit   : quotient bit produced by this step
module md_divstep #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem_in,
   input  logic [W-1:0] divisor,
   input  logic         bit_in,
   output logic [W-1:0] rem_out,
   output logic         q_bit
);

   logic [W:0] shifted;

   always_comb begin
      shifted = {rem_in, bit_in};
      q_bit   = (shifted >= {1'b0, divisor});
      // The true difference is below the divisor, so a W-bit subtract is exact.
      rem_out = q_bit ? (shifted[W-1:0] - divisor) : shifted[W-1:0];
   end

endmodule

// File: rtl/md_unit_iter.sv
// Iterative multiply/divide unit with HI/LO registers for the CPU EX stage.
//   CLK, MRST_n      : clock and asynchronous active-low reset
//   MDtype           : 100 mult, 101 multu, 110 div, 111 divu, others idle
//   RS, RT           : operands (multiplicand/dividend, multiplier/divisor)
//   Hold             : freeze all state this cycle
//   Kill             : abort the operation in flight
//   WrHI, WrLO       : MTHI / MTLO write strobes, data on WrData
//   HI, LO           : result registers
//   Ready            : 1 when idle and HI/LO are valid
//   DivZero          : sticky divide-by-zero flag, cleared by the next accepted op
module md_unit_iter
   import md_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int MUL_BPC   = 1,
   parameter int EARLY_OUT = 1
) (
   input  logic             CLK,
   input  logic             MRST_n,
   input  logic [2:0]       MDtype,
   input  logic [WIDTH-1:0] RS,
   input  logic [WIDTH-1:0] RT,
   input  logic             Hold,
   input  logic             Kill,
   input  logic             WrHI,
   input  logic             WrLO,
   input  logic [WIDTH-1:0] WrData,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             Ready,
   output logic             DivZero
);

   localparam int                CNT_W    = md_clog2(WIDTH);
   localparam logic [CNT_W-1:0]  MUL_LAST = CNT_W'(WIDTH / MUL_BPC - 1);
   localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(WIDTH - 1);

   md_state_e            state_q, state_d;
   logic [CNT_W-1:0]     count_q;
   logic [2*WIDTH-1:0]   acc_q;      // mult: product; div: {remainder, quotient/dividend}
   logic [2*WIDTH-1:0]   a_q;        // mult: multiplicand shifted to the current weight
   logic [WIDTH-1:0]     b_q;        // mult: remaining multiplier; div: divisor
   logic                 is_mul_q, neg_lo_q, neg_hi_q, dz_op_q;
   logic [WIDTH-1:0]     hi_q, lo_q;
   logic                 divzero_q;

   // Operation decode and operand magnitudes
   logic                 start_req, op_mul, op_signed, sa, sb, start_dz;
   logic [WIDTH-1:0]     mag_a, mag_b;

   always_comb begin
      start_req = (MDtype inside {MDTYPE_MULT, MDTYPE_MULTU, MDTYPE_DIV, MDTYPE_DIVU});
      op_mul    = (MDtype inside {MDTYPE_MULT, MDTYPE_MULTU});
      op_signed = (MDtype inside {MDTYPE_MULT, MDTYPE_DIV});
      sa        = op_signed & RS[WIDTH-1];
      sb        = op_signed & RT[WIDTH-1];
      mag_a     = sa ? (~RS + 1'b1) : RS;
      mag_b     = sb ? (~RT + 1'b1) : RT;
      start_dz  = !op_mul && (RT == '0) && (MDtype != MDTYPE_NONE);
   end

   // Multiply step: MUL_BPC partial products per cycle
   logic [2*WIDTH-1:0]   mul_sum;
   logic [WIDTH-1:0]     mpl_next;

   // NOTE: combinational blocks assign every output a default first so no latch is inferred.
   always_comb begin
      mul_sum = acc_q;
      for (int i = 0; i < MUL_BPC; i++) begin
         if (b_q[i]) mul_sum = mul_sum + (a_q << i);
      end
      mpl_next = b_q >> MUL_BPC;
   end

   // Divide step
   logic [WIDTH-1:0]     div_rem;
   logic                 div_q;

   md_divstep #(.W(WIDTH)) u_divstep (
      .rem_in  (acc_q[2*WIDTH-1:WIDTH]),
      .divisor (b_q),
      .bit_in  (acc_q[WIDTH-1]),
      .rem_out (div_rem),
      .q_bit   (div_q)
   );

   logic step_done;

   always_comb begin
      if (is_mul_q)
         step_done = (count_q == MUL_LAST) || ((EARLY_OUT != 0) && (mpl_next == '0));
      else
         step_done = (count_q == DIV_LAST);
   end

   // Sign fix-up applied on the FIX edge
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     acc_hi, acc_lo, fix_hi, fix_lo;

   always_comb begin
      acc_hi   = acc_q[2*WIDTH-1:WIDTH];
      acc_lo   = acc_q[WIDTH-1:0];
      prod_fix = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
      if (is_mul_q) begin
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
         fix_lo = prod_fix[WIDTH-1:0];
      end else begin
         fix_hi = neg_hi_q ? (~acc_hi + 1'b1) : acc_hi;
         fix_lo = neg_lo_q ? (~acc_lo + 1'b1) : acc_lo;
      end
   end

   // FSM: state register
   // NOTE: clocked state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK or negedge MRST_n) begin
      if (!MRST_n) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (!Hold) begin
         unique case (state_q)
            ST_IDLE: if (start_req) state_d = start_dz ? ST_FIX : ST_ITER;
            ST_ITER: if (Kill) state_d = ST_IDLE;
                     else if (step_done) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      Ready = (state_q == ST_IDLE);
   end

   // A write port is honoured in IDLE when no start competes, or alongside Kill.
   logic wr_ok;
   always_comb begin
      wr_ok = (state_q == ST_IDLE) ? !start_req : Kill;
   end

   // Datapath and architectural registers
   always_ff @(posedge CLK or negedge MRST_n) begin
      if (!MRST_n) begin
         count_q   <= '0;
         acc_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         is_mul_q  <= 1'b0;
         neg_lo_q  <= 1'b0;
         neg_hi_q  <= 1'b0;
         dz_op_q   <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         divzero_q <= 1'b0;
      end else if (!Hold) begin
         if (state_q == ST_IDLE && start_req) begin
            count_q   <= '0;
            is_mul_q  <= op_mul;
            dz_op_q   <= start_dz;
            divzero_q <= 1'b0;
            neg_lo_q  <= start_dz ? 1'b0 : (sa ^ sb);
            neg_hi_q  <= start_dz ? 1'b0 : (op_mul ? (sa ^ sb) : sa);
            b_q       <= mag_b;
            a_q       <= {{WIDTH{1'b0}}, mag_a};
            if (op_mul)        acc_q <= '0;
            else if (start_dz) acc_q <= {RS, {WIDTH{1'b1}}};
            else               acc_q <= {{WIDTH{1'b0}}, mag_a};
         end else if (state_q == ST_ITER && !Kill) begin
            count_q <= count_q + 1'b1;
            if (is_mul_q) begin
               acc_q <= mul_sum;
               a_q   <= a_q << MUL_BPC;
               b_q   <= mpl_next;
            end else begin
               acc_q <= {div_rem, acc_q[WIDTH-2:0], div_q};
            end
         end else if (state_q == ST_FIX && !Kill) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
            if (dz_op_q) divzero_q <= 1'b1;
         end

         if (wr_ok && WrHI) hi_q <= WrData;
         if (wr_ok && WrLO) lo_q <= WrData;
      end
   end

   assign HI      = hi_q;
   assign LO      = lo_q;
   assign DivZero = divzero_q;

endmodule
